// File: rtl/alu_host_driver.sv
// Host-side sequencer for the byte-serial ALU: issues BEGIN, op_code and operand bytes,
// gathers result bytes on END and returns a 16-bit response guarded by a watchdog.
module alu_host_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic [1:0]  op_code,
    output logic        BEGIN,
    output logic [7:0]  inbus,
    input  logic [7:0]  outbus,
    input  logic        END
);
    localparam logic [9:0] WD_LIMIT = TIMEOUT_CYCLES[9:0];

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLoad,
        StWaitEnd,
        StCapLo,
        StResp
    } state_e;

    state_e      r_state;
    logic [1:0]  r_op;
    logic [15:0] r_x;
    logic [7:0]  r_y;
    logic [1:0]  r_cnt;
    logic [9:0]  r_wd;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_timeout;
    logic [1:0]  r_op_code;
    logic        r_begin;
    logic [7:0]  r_inbus;

    logic [1:0]  w_last_idx;
    logic [1:0]  w_byte_idx;
    logic [7:0]  w_byte;
    logic [9:0]  w_wd_next;
    logic        w_wd_expire;

    // Divide sends a 16-bit dividend, so it has one more operand byte than the others.
    assign w_last_idx  = (r_op == 2'b11) ? 2'd2 : 2'd1;
    assign w_byte_idx  = (r_state == StStart) ? 2'd0 : r_cnt + 2'd1;
    assign w_wd_next   = (r_wd == 10'h3FF) ? r_wd : r_wd + 10'd1;
    assign w_wd_expire = (w_wd_next >= WD_LIMIT);

    always_comb begin
        w_byte = 8'h00;
        if (r_op == 2'b11) begin
            unique case (w_byte_idx)
                2'd0:    w_byte = r_x[15:8];
                2'd1:    w_byte = r_x[7:0];
                default: w_byte = r_y;
            endcase
        end else begin
            w_byte = (w_byte_idx == 2'd0) ? r_x[7:0] : r_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_op          <= 2'b00;
            r_x           <= 16'h0000;
            r_y           <= 8'h00;
            r_cnt         <= 2'd0;
            r_wd          <= 10'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 16'h0000;
            r_rsp_timeout <= 1'b0;
            r_op_code     <= 2'b00;
            r_begin       <= 1'b0;
            r_inbus       <= 8'h00;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_x       <= req_x;
                        r_y       <= req_y;
                        r_cnt     <= 2'd0;
                        r_op_code <= req_op;
                        r_begin   <= 1'b1;
                        r_state   <= StStart;
                    end
                end
                StStart: begin
                    r_begin <= 1'b0;
                    r_inbus <= w_byte;
                    r_state <= StLoad;
                end
                StLoad: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == w_last_idx) begin
                        r_inbus <= 8'h00;
                        r_wd    <= 10'd0;
                        r_state <= StWaitEnd;
                    end else begin
                        r_inbus <= w_byte;
                    end
                end
                StWaitEnd: begin
                    // END takes priority over a watchdog expiring on the same cycle.
                    if (END) begin
                        if (r_op[1]) begin
                            r_rsp_data[15:8] <= outbus;
                            r_state          <= StCapLo;
                        end else begin
                            r_rsp_data  <= {8'h00, outbus};
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end
                    end else if (w_wd_expire) begin
                        r_rsp_data    <= 16'h0000;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= StResp;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end
                StCapLo: begin
                    r_rsp_data[7:0] <= outbus;
                    r_rsp_valid     <= 1'b1;
                    r_state         <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_op_code     <= 2'b00;
                        r_state       <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready   = (r_state == StIdle);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign op_code     = r_op_code;
    assign BEGIN       = r_begin;
    assign inbus       = r_inbus;

endmodule
